// File: rtl/acq_frame_pkg.sv
// Shared constants, frame geometry and FSM encoding for the ADC frame scheduler.
package acq_frame_pkg;

  localparam int unsigned NUM_CH       = 4;
  localparam int unsigned BYTE_W       = 8;
  localparam logic [7:0]  SYNC_DEFAULT = 8'hA5;
  localparam int unsigned FRAME_LEN    = 1 + 2 * NUM_CH;
  localparam int unsigned FRAME_LEN_CK = FRAME_LEN + 1;
  localparam int unsigned IDX_W        = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SEND,
    ST_WAIT_ACK,
    ST_WAIT_DONE
  } fsm_state_t;

endpackage

// File: rtl/adc_frame_scheduler_if.sv
// UART transmit byte interface; the scheduler is the master and the UART the slave.
interface adc_frame_scheduler_if;
  import acq_frame_pkg::*;

  logic [BYTE_W-1:0] tx_data;
  logic              tx_en;
  logic              tx_write_en;
  logic              tx_ready;

  modport master (output tx_data, output tx_en, output tx_write_en, input tx_ready);
  modport slave  (input tx_data, input tx_en, input tx_write_en, output tx_ready);

endinterface

// File: rtl/adc_sample_collector.sv
// Per-channel sample latches and valid bits, complete-set detection and the frame snapshot.
module adc_sample_collector
  import acq_frame_pkg::*;
#(
  parameter int unsigned SAMPLE_W = 10
) (
  input  logic                              clk,
  input  logic                              reset_b,
  input  logic [NUM_CH*SAMPLE_W-1:0]        ch_data,
  input  logic [NUM_CH-1:0]                 ch_ready,
  input  logic                              take,
  output logic                              complete_c,
  output logic [NUM_CH-1:0][SAMPLE_W-1:0]   snap
);

  logic [NUM_CH-1:0]                valid;
  logic [NUM_CH-1:0][SAMPLE_W-1:0]  samples;
  logic [NUM_CH-1:0][SAMPLE_W-1:0]  ch_vec;

  assign ch_vec     = ch_data;
  assign complete_c = &valid;

  // A complete set clears the valid bits; pulses on that same edge start the next set.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      valid   <= '0;
      samples <= '0;
      snap    <= '0;
    end else begin
      valid <= complete_c ? ch_ready : (valid | ch_ready);
      for (int k = 0; k < NUM_CH; k++) begin
        if (ch_ready[k]) samples[k] <= ch_vec[k];
      end
      if (take) snap <= samples;
    end
  end

endmodule

// File: rtl/adc_frame_scheduler.sv
// Schedules one ADC sample set per frame onto the UART byte interface.
// Define FRAME_CHECKSUM_EN to append an XOR checksum of bytes 1..8 as a 10th byte.
module adc_frame_scheduler
  import acq_frame_pkg::*;
#(
  parameter int unsigned SAMPLE_W = 10,
  parameter int unsigned DECIM    = 1,
  parameter int unsigned ACK_TO   = 4096,
  parameter logic [7:0]  SYNC     = SYNC_DEFAULT
) (
  input  logic                       clk,
  input  logic                       reset_b,
  input  logic                       stream_en,
  input  logic [NUM_CH*SAMPLE_W-1:0] ch_data,
  input  logic [NUM_CH-1:0]          ch_ready,
  adc_frame_scheduler_if.master      tx,
  output logic                       busy,
  output logic [15:0]                frame_count,
  output logic [7:0]                 overrun_count,
  output logic                       tx_timeout
);

`ifdef FRAME_CHECKSUM_EN
  localparam int unsigned FRAME_BYTES = FRAME_LEN_CK;
`else
  localparam int unsigned FRAME_BYTES = FRAME_LEN;
`endif
  localparam int unsigned ACK_W    = 16;
  localparam int unsigned DEC_W    = 8;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_BYTES - 1);

  fsm_state_t                        state, state_next;
  logic [IDX_W-1:0]                  idx, idx_next;
  logic [ACK_W-1:0]                  ack_cnt, ack_cnt_next;
  logic [DEC_W-1:0]                  dec_cnt;
  logic                              complete_c, take_c, frame_done_c, timeout_c;
  logic                              strobe_next, busy_next, load_data_c;
  logic [NUM_CH-1:0][SAMPLE_W-1:0]   snap;
  logic [1:0]                        ch_sel;
  logic [SAMPLE_W-1:0]               samp;
  logic [7:0]                        mux_byte_c;

  assign take_c = complete_c && stream_en && (state == ST_IDLE) && (dec_cnt == DEC_W'(DECIM - 1));

  adc_sample_collector #(.SAMPLE_W(SAMPLE_W)) u_collector (
    .clk        (clk),
    .reset_b    (reset_b),
    .ch_data    (ch_data),
    .ch_ready   (ch_ready),
    .take       (take_c),
    .complete_c (complete_c),
    .snap       (snap)
  );

  // Next-state, byte index and ack-timeout counter.
  always_comb begin
    state_next   = state;
    idx_next     = idx;
    ack_cnt_next = ack_cnt;
    frame_done_c = 1'b0;
    timeout_c    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (take_c) begin
          state_next = ST_LOAD;
          idx_next   = '0;
        end
      end
      ST_LOAD: begin
        idx_next   = '0;
        state_next = ST_SEND;
      end
      ST_SEND: begin
        ack_cnt_next = '0;
        state_next   = ST_WAIT_ACK;
      end
      ST_WAIT_ACK: begin
        if (!tx.tx_ready) begin
          state_next = ST_WAIT_DONE;
        end else if (ack_cnt == ACK_W'(ACK_TO - 1)) begin
          state_next = ST_IDLE;
          timeout_c  = 1'b1;
        end else begin
          ack_cnt_next = ack_cnt + ACK_W'(1);
        end
      end
      ST_WAIT_DONE: begin
        if (tx.tx_ready) begin
          if (idx == LAST_IDX) begin
            state_next   = ST_IDLE;
            frame_done_c = 1'b1;
          end else begin
            idx_next   = idx + IDX_W'(1);
            state_next = ST_SEND;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Output decode from the next state so the registered outputs line up with the state.
  always_comb begin
    strobe_next = (state_next == ST_SEND);
    busy_next   = (state_next != ST_IDLE);
    load_data_c = (state_next == ST_LOAD) || (state_next == ST_SEND);
  end

`ifdef FRAME_CHECKSUM_EN
  logic [7:0] checksum_c;
  always_comb begin
    checksum_c = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      checksum_c = checksum_c ^ {2'(k), 6'(snap[k] >> 8)} ^ 8'(snap[k]);
    end
  end
`endif

  // Byte mux: odd indices carry {channel, high sample bits}, even indices the low byte.
  always_comb begin
    ch_sel     = 2'((idx_next - IDX_W'(1)) >> 1);
    samp       = snap[ch_sel];
    mux_byte_c = SYNC;
    if ((idx_next != '0) && (idx_next <= IDX_W'(2 * NUM_CH))) begin
      mux_byte_c = idx_next[0] ? {ch_sel, 6'(samp >> 8)} : 8'(samp);
    end
`ifdef FRAME_CHECKSUM_EN
    else if (idx_next == IDX_W'(FRAME_LEN)) begin
      mux_byte_c = checksum_c;
    end
`endif
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state          <= ST_IDLE;
      idx            <= '0;
      ack_cnt        <= '0;
      tx.tx_data     <= '0;
      tx.tx_en       <= 1'b0;
      tx.tx_write_en <= 1'b0;
      busy           <= 1'b0;
    end else begin
      state          <= state_next;
      idx            <= idx_next;
      ack_cnt        <= ack_cnt_next;
      tx.tx_en       <= strobe_next;
      tx.tx_write_en <= strobe_next;
      busy           <= busy_next;
      if (load_data_c) tx.tx_data <= mux_byte_c;
    end
  end

  // Decimation, frame/overrun counters and the sticky timeout flag.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      dec_cnt       <= '0;
      frame_count   <= '0;
      overrun_count <= '0;
      tx_timeout    <= 1'b0;
    end else begin
      if (!stream_en) begin
        dec_cnt <= '0;
      end else if (complete_c && (state == ST_IDLE)) begin
        dec_cnt <= take_c ? '0 : dec_cnt + DEC_W'(1);
      end
      if (complete_c && stream_en && (state != ST_IDLE) && (overrun_count != 8'hFF)) begin
        overrun_count <= overrun_count + 8'd1;
      end
      if (frame_done_c) frame_count <= frame_count + 16'd1;
      if (timeout_c)    tx_timeout  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_adc_frame_scheduler.sv
// Self-checking bench: two scheduler instances (DECIM=1 and DECIM=3), UART ack models,
// byte scoreboards per instance, a vector table plus hand-written corner sequences.
module tb_adc_frame_scheduler;

  typedef struct {
    logic [3:0][9:0] s;
    bit              en;
    bit              exp_frame;
  } vec_t;

  logic            clk;
  logic            reset_b;
  logic            stream_en;
  logic [3:0][9:0] ch_data;
  logic [3:0]      ch_ready;
  logic [3:0]      ch_ready_a, ch_ready_b;
  bit              sel_a, sel_b;
  logic            busy_a, busy_b, to_a, to_b;
  logic [15:0]     fc_a, fc_b;
  logic [7:0]      ov_a, ov_b;

  int  n_vec = 0;
  int  n_fail = 0;
  int  a_strobes = 0;
  int  ack_hold = 3;
  bit  ack_en_a = 1'b1;
  logic [7:0] qa[$];
  logic [7:0] qb[$];

  adc_frame_scheduler_if ifa ();
  adc_frame_scheduler_if ifb ();

  assign ch_ready_a = sel_a ? ch_ready : 4'b0;
  assign ch_ready_b = sel_b ? ch_ready : 4'b0;

  adc_frame_scheduler #(.SAMPLE_W(10), .DECIM(1), .ACK_TO(16), .SYNC(8'hA5)) dut_a (
    .clk(clk), .reset_b(reset_b), .stream_en(stream_en), .ch_data(ch_data),
    .ch_ready(ch_ready_a), .tx(ifa), .busy(busy_a), .frame_count(fc_a),
    .overrun_count(ov_a), .tx_timeout(to_a));

  adc_frame_scheduler #(.SAMPLE_W(10), .DECIM(3), .ACK_TO(16), .SYNC(8'hA5)) dut_b (
    .clk(clk), .reset_b(reset_b), .stream_en(stream_en), .ch_data(ch_data),
    .ch_ready(ch_ready_b), .tx(ifb), .busy(busy_b), .frame_count(fc_b),
    .overrun_count(ov_b), .tx_timeout(to_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // UART models: drop tx_ready after a write strobe, hold it low, then raise it.
  initial begin
    ifa.tx_ready = 1'b1;
    forever begin
      @(posedge clk);
      if (ifa.tx_write_en && ack_en_a) begin
        #1 ifa.tx_ready = 1'b0;
        repeat (ack_hold) @(posedge clk);
        #1 ifa.tx_ready = 1'b1;
      end
    end
  end

  initial begin
    ifb.tx_ready = 1'b1;
    forever begin
      @(posedge clk);
      if (ifb.tx_write_en) begin
        #1 ifb.tx_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 ifb.tx_ready = 1'b1;
      end
    end
  end

  // Scoreboard monitors: every write strobe pops one expected byte.
  always @(negedge clk) begin
    if (ifa.tx_write_en) begin
      a_strobes++;
      if (qa.size() == 0) check("a_unexpected_byte", {24'd0, ifa.tx_data}, 32'hFFFF_FFFF);
      else check("a_byte", {24'd0, ifa.tx_data}, {24'd0, qa.pop_front()});
    end
  end

  always @(negedge clk) begin
    if (ifb.tx_write_en) begin
      if (qb.size() == 0) check("b_unexpected_byte", {24'd0, ifb.tx_data}, 32'hFFFF_FFFF);
      else check("b_byte", {24'd0, ifb.tx_data}, {24'd0, qb.pop_front()});
    end
  end

  task automatic push_frame(input bit to_b, input logic [3:0][9:0] s);
    logic [7:0] b[$];
    logic [7:0] hi, lo, ck;
    ck = 8'h00;
    b.push_back(8'hA5);
    for (int k = 0; k < 4; k++) begin
      hi = 8'((k << 6) | (s[k] >> 8));
      lo = s[k][7:0];
      b.push_back(hi);
      b.push_back(lo);
      ck = ck ^ hi ^ lo;
    end
`ifdef FRAME_CHECKSUM_EN
    b.push_back(ck);
`endif
    foreach (b[i]) begin
      if (to_b) qb.push_back(b[i]);
      else      qa.push_back(b[i]);
    end
  endtask

  task automatic send_set(input logic [3:0][9:0] s, input bit seq);
    @(negedge clk);
    ch_data = s;
    if (seq) begin
      for (int k = 0; k < 4; k++) begin
        ch_ready = 4'(1 << k);
        @(negedge clk);
      end
    end else begin
      ch_ready = 4'hF;
      @(negedge clk);
    end
    ch_ready = 4'h0;
  endtask

  task automatic wait_idle(input bit to_b, input int budget);
    int n;
    n = 0;
    repeat (4) @(negedge clk);
    while (((to_b ? busy_b : busy_a) || (to_b ? qb.size() : qa.size()) != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) check("wait_idle_budget", 32'(n), 32'(budget - 1));
  endtask

  function automatic vec_t mk(input logic [9:0] c0, input logic [9:0] c1, input logic [9:0] c2,
                              input logic [9:0] c3, input bit en, input bit ex);
    vec_t v;
    v.s[0] = c0; v.s[1] = c1; v.s[2] = c2; v.s[3] = c3;
    v.en = en; v.exp_frame = ex;
    return v;
  endfunction

  initial begin
    vec_t            tbl[5];
    logic [3:0][9:0] s;
    int              exp_fc;
    int              base;
    int              n;

    reset_b = 1'b0; stream_en = 1'b0; ch_data = '0; ch_ready = 4'h0;
    sel_a = 1'b1; sel_b = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_tx_data", {24'd0, ifa.tx_data}, 32'd0);
    check("rst_tx_en", {31'd0, ifa.tx_en}, 32'd0);
    check("rst_busy", {31'd0, busy_a}, 32'd0);
    check("rst_frame_count", {16'd0, fc_a}, 32'd0);
    reset_b = 1'b1;
    stream_en = 1'b1;
    @(negedge clk);

    tbl[0] = mk(10'h3FF, 10'h001, 10'h2AA, 10'h155, 1'b1, 1'b1);
    tbl[1] = mk(10'h000, 10'h000, 10'h000, 10'h000, 1'b1, 1'b1);
    tbl[2] = mk(10'h123, 10'h2DC, 10'h0FF, 10'h300, 1'b0, 1'b0);
    tbl[3] = mk(10'h3FF, 10'h3FF, 10'h3FF, 10'h3FF, 1'b1, 1'b1);
    tbl[4] = mk(10'h100, 10'h0FE, 10'h201, 10'h1FF, 1'b1, 1'b1);
    exp_fc = 0;
    for (int i = 0; i < 5; i++) begin
      stream_en = tbl[i].en;
      if (tbl[i].exp_frame) begin
        push_frame(1'b0, tbl[i].s);
        exp_fc++;
      end
      send_set(tbl[i].s, 1'b1);
      wait_idle(1'b0, 500);
      check("tbl_frame_count", {16'd0, fc_a}, 32'(exp_fc));
      check("tbl_overrun", {24'd0, ov_a}, 32'd0);
    end
    stream_en = 1'b1;

    // stream_en falling mid-frame lets the frame finish.
    s = tbl[4].s;
    s[2] = 10'h0AA;
    base = a_strobes;
    push_frame(1'b0, s);
    send_set(s, 1'b0);
    n = 0;
    while (a_strobes < base + 2 && n < 100) begin @(negedge clk); n++; end
    stream_en = 1'b0;
    wait_idle(1'b0, 500);
    exp_fc++;
    check("stream_off_frame_count", {16'd0, fc_a}, 32'(exp_fc));
    stream_en = 1'b1;

    // Overrun: sets arriving while a frame is held in progress by a slow UART.
    ack_hold = 1000;
    s = tbl[0].s;
    push_frame(1'b0, s);
    send_set(s, 1'b0);
    send_set(tbl[3].s, 1'b0);
    repeat (6) @(negedge clk);
    check("overrun_one", {24'd0, ov_a}, 32'd1);
    for (int i = 0; i < 300; i++) send_set(tbl[4].s, 1'b0);
    check("overrun_saturate", {24'd0, ov_a}, 32'hFF);
    ack_hold = 3;
    wait_idle(1'b0, 3000);
    exp_fc++;
    check("overrun_single_frame", {16'd0, fc_a}, 32'(exp_fc));

    // ACK timeout: tx_ready never falls after the first write.
    ack_en_a = 1'b0;
    qa.push_back(8'hA5);
    send_set(tbl[1].s, 1'b0);
    n = 0;
    while (!ifa.tx_write_en && n < 20) begin @(negedge clk); n++; end
    check("timeout_strobe_seen", {31'd0, ifa.tx_write_en}, 32'd1);
    repeat (8) @(negedge clk);
    check("timeout_early", {31'd0, to_a}, 32'd0);
    check("timeout_busy_early", {31'd0, busy_a}, 32'd1);
    repeat (12) @(negedge clk);
    check("timeout_flag", {31'd0, to_a}, 32'd1);
    check("timeout_idle", {31'd0, busy_a}, 32'd0);
    check("timeout_frame_count", {16'd0, fc_a}, 32'(exp_fc));
    check("timeout_queue", 32'(qa.size()), 32'd0);
    ack_en_a = 1'b1;

    // Decimation by 3 on the second instance: sets 3 and 6 are framed.
    sel_a = 1'b0; sel_b = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      s = tbl[0].s;
      s[0] = 10'(i * 37);
      s[3] = 10'(10'h3FF - i);
      if (i % 3 == 0) push_frame(1'b1, s);
      send_set(s, 1'b1);
      wait_idle(1'b1, 500);
    end
    check("decim_frame_count", {16'd0, fc_b}, 32'd2);
    check("decim_overrun", {24'd0, ov_b}, 32'd0);
    sel_a = 1'b1; sel_b = 1'b0;

    // Reset mid-frame, then a clean frame afterwards.
    base = a_strobes;
    push_frame(1'b0, tbl[3].s);
    send_set(tbl[3].s, 1'b0);
    n = 0;
    while (a_strobes < base + 4 && n < 200) begin @(negedge clk); n++; end
    reset_b = 1'b0;
    qa.delete();
    repeat (2) @(negedge clk);
    check("midrst_tx_data", {24'd0, ifa.tx_data}, 32'd0);
    check("midrst_tx_en", {31'd0, ifa.tx_en}, 32'd0);
    check("midrst_tx_write_en", {31'd0, ifa.tx_write_en}, 32'd0);
    check("midrst_busy", {31'd0, busy_a}, 32'd0);
    check("midrst_frame_count", {16'd0, fc_a}, 32'd0);
    check("midrst_overrun", {24'd0, ov_a}, 32'd0);
    check("midrst_timeout", {31'd0, to_a}, 32'd0);
    reset_b = 1'b1;
    n = 0;
    while (!ifa.tx_ready && n < 50) begin @(negedge clk); n++; end
    push_frame(1'b0, tbl[4].s);
    send_set(tbl[4].s, 1'b1);
    wait_idle(1'b0, 500);
    check("postrst_frame_count", {16'd0, fc_a}, 32'd1);
    check("final_queue_b", 32'(qb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
